tl45_fetch: RTL and testbench

Instruction fetch stage of the tl45 pipeline, directly upstream of decode. It owns the program counter and fetches one 32-bit word per instruction over a Wishbone B4 pipelined master port, one request outstanding at a time. It presents `{pc, inst}` to decode through a registered output buffer that honours decode's stall, injects NOP bubbles (`inst = 0`) when it has no word ready, and aborts and redirects on a branch flush.

---
 rtl/tl45_pkg.sv | 16 +
 rtl/tl45_fetch.sv | 143 ++++++++++++++
 tb/tb_tl45_fetch.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tl45_pkg.sv
// Shared tl45 pipeline definitions: fetch FSM states and fixed instruction encodings.
package tl45_pkg;

  typedef enum logic [2:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD,
    FETCH_HALT
  } fetch_state_t;

  localparam logic [31:0] TL45_NOP          = 32'h0000_0000;
  localparam logic [31:0] TL45_ILLEGAL_INST = 32'hFFFF_FFFF;
  localparam logic [31:0] TL45_PC_STEP      = 32'd4;

endpackage

// File: rtl/tl45_fetch.sv
// tl45 instruction fetch: owns the PC, issues single-outstanding Wishbone reads and
// presents {pc, inst} to decode through a registered, stall-aware output buffer.
module tl45_fetch
  import tl45_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_branch_valid,
  input  logic [31:0] i_branch_pc,
  output logic [31:0] o_buf_pc,
  output logic [31:0] o_buf_inst,
  output logic        o_fetch_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [29:0] o_wb_addr,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data
);

  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic         hold_err_q, hold_err_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic [31:0]  buf_inst_q, buf_inst_d;
  logic         fetch_err_q, fetch_err_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= FETCH_IDLE;
      pc_q        <= RESET_PC & PC_ALIGN_MASK;
      hold_q      <= TL45_NOP;
      hold_err_q  <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_inst_q  <= TL45_NOP;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_q      <= hold_d;
      hold_err_q  <= hold_err_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    hold_err_d  = hold_err_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    fetch_err_d = 1'b0;

    // An unstalled cycle presents a bubble unless a word is loaded below.
    if (!i_pipe_stall) begin
      buf_pc_d   = 32'h0;
      buf_inst_d = TL45_NOP;
    end

    case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;

      FETCH_REQ: begin
        if (!i_wb_stall) state_d = FETCH_WAIT;
      end

      FETCH_WAIT: begin
        if (i_wb_ack) begin
          if (!i_pipe_stall) begin
            buf_pc_d   = pc_q;
            buf_inst_d = i_wb_data;
            pc_d       = pc_q + TL45_PC_STEP;
            state_d    = FETCH_REQ;
          end else begin
            hold_d     = i_wb_data;
            hold_err_d = 1'b0;
            state_d    = FETCH_HOLD;
          end
        end else if (i_wb_err) begin
          fetch_err_d = 1'b1;
          if (!i_pipe_stall) begin
            buf_pc_d   = pc_q;
            buf_inst_d = TL45_ILLEGAL_INST;
            state_d    = FETCH_HALT;
          end else begin
            hold_d     = TL45_ILLEGAL_INST;
            hold_err_d = 1'b1;
            state_d    = FETCH_HOLD;
          end
        end
      end

      FETCH_HOLD: begin
        if (!i_pipe_stall) begin
          buf_pc_d   = pc_q;
          buf_inst_d = hold_q;
          if (hold_err_q) begin
            state_d = FETCH_HALT;
          end else begin
            pc_d    = pc_q + TL45_PC_STEP;
            state_d = FETCH_REQ;
          end
        end
      end

      FETCH_HALT: state_d = FETCH_HALT;

      default: state_d = FETCH_IDLE;
    endcase

    // Flush overrides everything, including a response arriving this cycle.
    if (i_branch_valid) begin
      pc_d        = i_branch_pc & PC_ALIGN_MASK;
      buf_pc_d    = 32'h0;
      buf_inst_d  = TL45_NOP;
      hold_d      = TL45_NOP;
      hold_err_d  = 1'b0;
      fetch_err_d = 1'b0;
      state_d     = FETCH_IDLE;
    end
  end

  always_comb begin
    o_wb_cyc  = (state_q == FETCH_REQ) || (state_q == FETCH_WAIT);
    o_wb_stb  = (state_q == FETCH_REQ);
    o_wb_addr = pc_q[31:2];
  end

  assign o_buf_pc    = buf_pc_q;
  assign o_buf_inst  = buf_inst_q;
  assign o_fetch_err = fetch_err_q;

endmodule

// File: tb/tb_tl45_fetch.sv
// Randomized scoreboard bench for tl45_fetch: a Wishbone slave model, an instruction-stream
// reference model and a monitor comparing every presented decode slot.
module tb_tl45_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  localparam logic [31:0] BOOT_PC = 32'h0000_0100;
  localparam logic [31:0] ERR_PC  = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, br;
  logic [31:0] bpc;
  logic        ack, err, wbstall;
  logic [31:0] data;
  logic [31:0] o_buf_pc, o_buf_inst;
  logic        o_fetch_err, o_wb_cyc, o_wb_stb;
  logic [29:0] o_wb_addr;

  always #5 clk = ~clk;

  tl45_fetch #(.RESET_PC(BOOT_PC)) dut (
    .i_clk(clk), .i_reset(rst), .i_pipe_stall(stall),
    .i_branch_valid(br), .i_branch_pc(bpc),
    .o_buf_pc(o_buf_pc), .o_buf_inst(o_buf_inst), .o_fetch_err(o_fetch_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_addr(o_wb_addr),
    .i_wb_ack(ack), .i_wb_stall(wbstall), .i_wb_err(err), .i_wb_data(data)
  );

  int checks = 0;
  int errors = 0;
  item_t exp_q[$];

  // Reference model and slave state
  logic [31:0] model_pc, pend_pc;
  logic        halted, pending;
  int          lat;
  // Previous-cycle observations
  logic        prev_stall, prev_br, prev_err, prev_ack_stalled, prev_req_stalled;
  logic [31:0] prev_buf_pc, prev_buf_inst;
  logic [29:0] prev_addr;
  int          k, first_k;
  // Knobs
  int          stall_pct, br_pct, max_lat, wbstall_pct;
  logic        accept_en;
  int          force_stall, force_wbstall;
  logic        stall_on_ack_en, flush_on_ack_en, force_br_en;
  logic [31:0] flush_on_ack_pc, force_br_pc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3))
      0:       return ERR_PC;
      1:       return 32'hFFFF_FFF4;
      2:       return $urandom & 32'h0000_03FF;
      default: return $urandom;
    endcase
  endfunction

  task automatic reset_model();
    exp_q.delete();
    model_pc = BOOT_PC; halted = 1'b0; pending = 1'b0; lat = 0; pend_pc = 32'h0;
    prev_stall = 1'b0; prev_br = 1'b0; prev_err = 1'b0;
    prev_ack_stalled = 1'b0; prev_req_stalled = 1'b0;
    prev_buf_pc = 32'h0; prev_buf_inst = 32'h0; prev_addr = 30'h0;
    k = 0; first_k = -1;
  endtask

  task automatic step();
    item_t e;
    // Monitor: what the last clock edge produced
    if (prev_br) begin
      check32("flush_buf_pc", o_buf_pc, 32'h0);
      check32("flush_buf_inst", o_buf_inst, 32'h0);
      check32("flush_cyc_drop", 32'(o_wb_cyc), 32'h0);
    end else if (prev_stall) begin
      check32("stall_hold_pc", o_buf_pc, prev_buf_pc);
      check32("stall_hold_inst", o_buf_inst, prev_buf_inst);
    end else if (o_buf_inst != 32'h0) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_inst: got pc=%h inst=%h expected none", o_buf_pc, o_buf_inst);
      end else begin
        e = exp_q.pop_front();
        check32("inst_pc", o_buf_pc, e.pc);
        check32("inst_word", o_buf_inst, e.inst);
        if (first_k < 0) first_k = k;
      end
    end else begin
      check32("bubble_pc", o_buf_pc, 32'h0);
    end
    check32("fetch_err", 32'(o_fetch_err), 32'(prev_err));
    if (halted && !prev_br) check32("halt_cyc", 32'(o_wb_cyc), 32'h0);
    if (prev_ack_stalled) check32("hold_cyc", 32'(o_wb_cyc), 32'h0);
    if (prev_req_stalled && !prev_br) begin
      check32("wbstall_stb", 32'(o_wb_stb), 32'h1);
      check32("wbstall_addr", 32'(o_wb_addr), 32'(prev_addr));
    end

    // Drive next cycle's inputs
    ack = 1'b0; err = 1'b0; wbstall = 1'b0; data = 32'hDEAD_BEEF; br = 1'b0; bpc = $urandom;
    stall = (force_stall > 0) ? 1'b1 : ($urandom_range(99) < stall_pct);
    if (force_stall > 0) force_stall--;
    if (force_br_en) begin
      br = 1'b1; bpc = force_br_pc; force_br_en = 1'b0;
    end else if ($urandom_range(99) < br_pct) begin
      br = 1'b1; bpc = pick_target();
    end

    if (!o_wb_cyc) pending = 1'b0;
    if (pending && o_wb_cyc && !o_wb_stb) begin
      if (lat > 0) lat--;
      else begin
        pending = 1'b0;
        if (flush_on_ack_en && !br) begin
          br = 1'b1; bpc = flush_on_ack_pc; flush_on_ack_en = 1'b0;
        end
        if (pend_pc == ERR_PC) err = 1'b1;
        else begin ack = 1'b1; data = ~pend_pc; end
        if (!br) begin
          if (err) begin
            exp_q.push_back('{pc: pend_pc, inst: 32'hFFFF_FFFF});
            halted = 1'b1;
          end else begin
            exp_q.push_back('{pc: pend_pc, inst: ~pend_pc});
            model_pc = model_pc + 32'd4;
          end
          if (stall_on_ack_en) begin
            stall = 1'b1; force_stall = 2; stall_on_ack_en = 1'b0;
          end
        end
      end
    end else if (o_wb_cyc && o_wb_stb) begin
      wbstall = (force_wbstall > 0) || !accept_en || ($urandom_range(99) < wbstall_pct);
      if (force_wbstall > 0) force_wbstall--;
      if (!wbstall && !br) begin
        check32("fetch_addr", 32'(o_wb_addr), 32'(model_pc[31:2]));
        pending = 1'b1; pend_pc = model_pc; lat = $urandom_range(max_lat);
      end
    end

    if (br) begin
      exp_q.delete(); pending = 1'b0; halted = 1'b0; model_pc = bpc & 32'hFFFF_FFFC;
    end

    prev_stall       = stall;
    prev_br          = br;
    prev_err         = err && !br;
    prev_ack_stalled = (ack || err) && stall && !br;
    prev_req_stalled = o_wb_cyc && o_wb_stb && wbstall;
    prev_buf_pc      = o_buf_pc;
    prev_buf_inst    = o_buf_inst;
    prev_addr        = o_wb_addr;
    k++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br = 1'b0; bpc = 32'h0;
    ack = 1'b0; err = 1'b0; wbstall = 1'b0; data = 32'h0;
    stall_pct = 0; br_pct = 0; max_lat = 0; wbstall_pct = 0; accept_en = 1'b1;
    force_stall = 0; force_wbstall = 0;
    stall_on_ack_en = 1'b0; flush_on_ack_en = 1'b0; force_br_en = 1'b0;
    flush_on_ack_pc = 32'h0; force_br_pc = 32'h0;
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_buf_pc", o_buf_pc, 32'h0);
    check32("rst_buf_inst", o_buf_inst, 32'h0);
    check32("rst_cyc", 32'(o_wb_cyc), 32'h0);
    check32("rst_stb", 32'(o_wb_stb), 32'h0);
    check32("rst_addr", 32'(o_wb_addr), 32'h40);
    check32("rst_err", 32'(o_fetch_err), 32'h0);
    rst = 1'b0;

    // Zero-wait startup: first word three cycles after release
    run(12);
    check32("first_latency", 32'(first_k), 32'd3);

    // Decode stall across an ack
    stall_on_ack_en = 1'b1;
    run(14);
    // Slave stalls the request strobe
    force_wbstall = 4;
    run(14);
    // Flush coinciding with ack
    flush_on_ack_en = 1'b1; flush_on_ack_pc = 32'h0000_2002;
    run(12);
    // Bus error at 0x10, then resume at 0x0
    force_br_en = 1'b1; force_br_pc = ERR_PC;
    run(12);
    force_br_en = 1'b1; force_br_pc = 32'h0;
    run(10);
    // PC wrap
    force_br_en = 1'b1; force_br_pc = 32'hFFFF_FFF8;
    run(12);

    // Random traffic
    stall_pct = 30; br_pct = 4; max_lat = 2; wbstall_pct = 25;
    run(3000);

    // Drain: no new requests accepted, everything fetched must be presented
    stall_pct = 0; br_pct = 0; accept_en = 1'b0;
    run(10);
    check32("drain_empty", 32'(exp_q.size()), 32'h0);

    // Asynchronous reset mid-transaction
    accept_en = 1'b1;
    run(5);
    rst = 1'b1;
    #1;
    check32("async_rst_cyc", 32'(o_wb_cyc), 32'h0);
    check32("async_rst_inst", o_buf_inst, 32'h0);
    check32("async_rst_addr", 32'(o_wb_addr), 32'h40);
    @(negedge clk);
    stall = 1'b0; br = 1'b0; ack = 1'b0; err = 1'b0; wbstall = 1'b0;
    max_lat = 0; wbstall_pct = 0;
    rst = 1'b0;
    reset_model();
    run(10);
    check32("rerun_latency", 32'(first_k), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
